popcount_acc_pipe: RTL and testbench
====================================

// Module: popcount_acc_pipe
// PURPOSE
//  Parametrised, pipelined population counter with valid/ready flow control, per-beat bit mask,
//  ones/zeros mode select and an optional per-frame running accumulator.
//  Sits in the req/cpl path to count enabled lanes, byte enables or credits per beat, and to total
//  them across multi-beat frames.
//  The tree is a log2(WIDTH)-level adder tree with a register inserted every STAGE levels.
// PARAMETERS
//  WIDTH  32  input vector width; power of two, >= 2
//  STAGE  2   register after every STAGE tree levels; 0 = fully combinational tree
//  ACC_W  16  accumulator width; must be >= CNT_W
//  Derived:
//   LEVEL = log2(WIDTH)
//   CNT_W = LEVEL+1
//   NREG  = (STAGE==0) ? 0 : LEVEL/STAGE (integer division)
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      input beat accepted when in_valid & in_ready
//  in_data    in   WIDTH  vector to count
//  in_mask    in   WIDTH  1 = bit participates in the count
//  in_mode    in   1      0 = count ones, 1 = count zeros (of masked bits)
//  in_last    in   1      last beat of frame
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_cnt    out  CNT_W  count for this beat, 0..WIDTH
//  out_last   out  1      in_last delayed with its beat
//  out_acc    out  ACC_W  frame running total including this beat
//  out_ovf    out  1      sticky frame overflow flag
// BEHAVIOUR
//  - Operand: eff = (in_mode ? ~in_data : in_data) & in_mask.
//    Tree level i adds adjacent 2**i-bit fields, zero-extended so no carry is lost.
//  - Pipeline: NREG tree registers plus one output register.
//    Latency from accept to out_valid = NREG+1 cycles.
//  - Flow control: global advance = ~out_valid | out_ready; in_ready = advance.
//    All stage registers and their valid bits shift only on advance.
//    Bubbles are not collapsed. Data is held stable while out_valid & ~out_ready.
//  - The valid bit travels with data. A stage with valid=0 contributes nothing to the accumulator.
//  - Accumulator: updates in the output stage when a valid beat enters it.
//    out_acc = acc_prev + cnt, saturating at 2**ACC_W-1.
//    out_ovf is set on saturation and stays set until the frame ends.
//    After a beat with out_last is accepted downstream, acc_prev and ovf clear to 0.
//    A single-beat frame gives out_acc = out_cnt.
//  - Reset values: out_valid=0, out_cnt=0, out_last=0, out_acc=0, out_ovf=0, all stage valids 0.
//    in_ready=1 out of reset.
//  - Reset mid-operation: all in-flight beats are dropped and the accumulator clears.
//    Nothing is emitted afterwards for those beats.
//  - Simultaneous accept and output in one cycle: both complete, so a full-rate stream is sustained.
//  - in_mask = 0: out_cnt = 0 in either mode.
//    All-ones data, full mask, mode 0: out_cnt = WIDTH.
//  - out_cnt is 0 whenever out_valid = 0.
// CONFIGURATION
//  POPCOUNT_ACC_EN defined:
//   - accumulator, saturation and out_ovf logic are present as described above.
//  POPCOUNT_ACC_EN undefined:
//   - no accumulator registers are built; out_acc ties to 0 and out_ovf ties to 0.
//   - out_last still passes through; cnt, latency and handshake are unchanged.
// TESTING
//  1) WIDTH=32, STAGE=2, mask all ones, mode 0, data 32'hFFFF_FFFF, then 32'h0, then 32'h8000_0001
//     -> out_cnt 32, 0, 2 in order, each NREG+1=3 cycles after accept.
//  2) mode 1, data 32'h0000_00FF, mask 32'h0000_FFFF -> out_cnt=8.
//     Same beat with mask 0 -> out_cnt=0.
//  3) Hold out_ready=0 for 5 cycles with a 4-beat stream
//     -> in_ready drops once the pipe fills; out_* stay stable; no beat is lost or duplicated.
//     Release -> 4 results in order, one per cycle.
//  4) POPCOUNT_ACC_EN, ACC_W=6, frame of 3 beats with counts 32,32,5
//     -> out_acc 32, 63, 63; out_ovf 0, 1, 1.
//     Next frame's first beat, count 4 -> out_acc=4, out_ovf=0.
//  5) Assert rst for 1 cycle with 2 beats in flight
//     -> next cycle out_valid=0, out_acc=0, in_ready=1; the dropped beats never appear.
//  6) STAGE=0, continuous valid, out_ready=1, 100 random beats
//     -> latency 1; out_cnt matches the model popcount every cycle.
//     Without POPCOUNT_ACC_EN, out_acc and out_ovf are always 0.

Source files
------------

// File: rtl/popcount_acc_pipe.sv
// Pipelined masked popcount with valid/ready flow control and optional per-frame accumulator.
// Define POPCOUNT_ACC_EN to build the accumulator, saturation and sticky overflow logic.
module popcount_acc_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STAGE = 2,
  parameter int unsigned ACC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [WIDTH-1:0]         in_mask,
  input  logic                     in_mode,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH):0]   out_cnt,
  output logic                     out_last,
  output logic [ACC_W-1:0]         out_acc,
  output logic                     out_ovf
);

  localparam int unsigned LEVEL = $clog2(WIDTH);
  localparam int unsigned CNT_W = LEVEL + 1;
  // Safe modulus divisor when STAGE is 0 (fully combinational tree).
  localparam int unsigned STG   = (STAGE == 0) ? 1 : STAGE;

  logic             advance;
  logic [WIDTH-1:0] eff;

  // Every tree level is carried at full count width so no carry is lost.
  logic [CNT_W-1:0] lvl      [0:LEVEL][WIDTH];
  logic             lvl_vld  [0:LEVEL];
  logic             lvl_last [0:LEVEL];

  logic             out_valid_q;
  logic             out_last_q;
  logic [CNT_W-1:0] out_cnt_q;

  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;
  assign eff      = (in_mode ? ~in_data : in_data) & in_mask;

  for (genvar j = 0; j < WIDTH; j++) begin : g_leaf
    assign lvl[0][j] = {{(CNT_W-1){1'b0}}, eff[j]};
  end
  assign lvl_vld[0]  = in_valid;
  assign lvl_last[0] = in_last;

  for (genvar l = 1; l <= LEVEL; l++) begin : g_lvl
    localparam int unsigned N = WIDTH >> l;
    logic [CNT_W-1:0] sum [N];

    for (genvar j = 0; j < N; j++) begin : g_add
      assign sum[j] = lvl[l-1][2*j] + lvl[l-1][2*j+1];
    end

    if ((STAGE != 0) && ((l % STG) == 0)) begin : g_reg
      logic [CNT_W-1:0] sum_q [N];
      logic             vld_q;
      logic             last_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q  <= 1'b0;
          last_q <= 1'b0;
          for (int j = 0; j < N; j++) sum_q[j] <= '0;
        end else if (advance) begin
          vld_q  <= lvl_vld[l-1];
          last_q <= lvl_last[l-1];
          sum_q  <= sum;
        end
      end

      for (genvar j = 0; j < N; j++) begin : g_out
        assign lvl[l][j] = sum_q[j];
      end
      assign lvl_vld[l]  = vld_q;
      assign lvl_last[l] = last_q;
    end else begin : g_comb
      for (genvar j = 0; j < N; j++) begin : g_out
        assign lvl[l][j] = sum[j];
      end
      assign lvl_vld[l]  = lvl_vld[l-1];
      assign lvl_last[l] = lvl_last[l-1];
    end

    for (genvar j = N; j < WIDTH; j++) begin : g_pad
      assign lvl[l][j] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_cnt_q   <= '0;
    end else if (advance) begin
      out_valid_q <= lvl_vld[LEVEL];
      out_last_q  <= lvl_vld[LEVEL] & lvl_last[LEVEL];
      out_cnt_q   <= lvl_vld[LEVEL] ? lvl[LEVEL][0] : '0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_cnt   = out_cnt_q;

`ifdef POPCOUNT_ACC_EN
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_base;
  logic             ovf_q;
  logic             ovf_base;
  logic             frame_done;
  logic [ACC_W:0]   acc_sum;

  // A held last beat is only replaced on advance, which implies it was accepted.
  always_comb begin
    frame_done = out_valid_q & out_last_q;
    acc_base   = frame_done ? '0 : acc_q;
    ovf_base   = frame_done ? 1'b0 : ovf_q;
    acc_sum    = {1'b0, acc_base} + (ACC_W+1)'(lvl[LEVEL][0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      if (lvl_vld[LEVEL]) begin
        acc_q <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        ovf_q <= ovf_base | acc_sum[ACC_W];
      end else begin
        acc_q <= acc_base;
        ovf_q <= ovf_base;
      end
    end
  end

  assign out_acc = acc_q;
  assign out_ovf = ovf_q;
`else
  assign out_acc = '0;
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_acc_pipe.sv
// Directed bench for popcount_acc_pipe: vector table plus backpressure, reset and
// combinational-tree streaming sequences.
module tb_popcount_acc_pipe;

`ifdef POPCOUNT_ACC_EN
  localparam bit AccEn = 1'b1;
`else
  localparam bit AccEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT 0: WIDTH=32, STAGE=2, ACC_W=6
  logic        in_valid, in_ready, in_mode, in_last;
  logic [31:0] in_data, in_mask;
  logic        out_valid, out_ready, out_last, out_ovf;
  logic [5:0]  out_cnt;
  logic [5:0]  out_acc;

  // DUT 1: WIDTH=32, STAGE=0, ACC_W=16
  logic        s_in_valid, s_in_ready, s_in_mode, s_in_last;
  logic [31:0] s_in_data, s_in_mask;
  logic        s_out_valid, s_out_ready, s_out_last, s_out_ovf;
  logic [5:0]  s_out_cnt;
  logic [15:0] s_out_acc;

  popcount_acc_pipe #(.WIDTH(32), .STAGE(2), .ACC_W(6)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt),
    .out_last  (out_last),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  popcount_acc_pipe #(.WIDTH(32), .STAGE(0), .ACC_W(16)) u_dut_comb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_mask   (s_in_mask),
    .in_mode   (s_in_mode),
    .in_last   (s_in_last),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_cnt   (s_out_cnt),
    .out_last  (s_out_last),
    .out_acc   (s_out_acc),
    .out_ovf   (s_out_ovf)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        mode;
    logic        last;
    int          cnt;
    int          acc;
    logic        ovf;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] m, input logic md,
                       input logic lst);
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    in_mode  = md;
    in_last  = lst;
  endtask

  function automatic int popcnt(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] bp_data [4];
    int          bp_cnt  [4];
    int          bp_acc  [4];
    int          k, n;
    int          prev_cnt, prev_acc, base;
    logic        prev_valid;
    logic [31:0] d, m;
    logic        md, lst;

    tbl[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32, 32, 1'b0};
    tbl[1]  = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1,  0,  0, 1'b0};
    tbl[2]  = '{32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1,  2,  2, 1'b0};
    tbl[3]  = '{32'h0000_00FF, 32'h0000_FFFF, 1'b1, 1'b1,  8,  8, 1'b0};
    tbl[4]  = '{32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b1,  0,  0, 1'b0};
    tbl[5]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1,  0,  0, 1'b0};
    tbl[6]  = '{32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0, 1'b1, 16, 16, 1'b0};
    tbl[7]  = '{32'h1234_5678, 32'hF0F0_F0F0, 1'b1, 1'b1,  8,  8, 1'b0};
    tbl[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32, 32, 1'b0};
    tbl[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32, 63, 1'b1};
    tbl[10] = '{32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b1,  5, 63, 1'b1};
    tbl[11] = '{32'h0000_000F, 32'hFFFF_FFFF, 1'b0, 1'b1,  4,  4, 1'b0};

    bp_data = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_00FF, 32'h0000_000F};
    bp_cnt  = '{32, 16, 8, 4};
    bp_acc  = '{32, 48, 56, 60};

    rst       = 1'b1;
    in_valid  = 1'b0; in_data = '0; in_mask = '0; in_mode = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_in_mask = '0; s_in_mode = 1'b0; s_in_last = 1'b0;
    s_out_ready = 1'b1;
    step();
    step();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_cnt",   32'(out_cnt),   0);
    chk("rst out_last",  32'(out_last),  0);
    chk("rst out_acc",   32'(out_acc),   0);
    chk("rst out_ovf",   32'(out_ovf),   0);
    chk("rst in_ready",  32'(in_ready),  1);
    rst = 1'b0;

    // Table: one beat at a time, result expected exactly 3 cycles after accept.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].data, tbl[i].mask, tbl[i].mode, tbl[i].last);
      chk("tbl in_ready", 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      chk("tbl early out_valid", 32'(out_valid), 0);
      chk("tbl idle out_cnt",    32'(out_cnt),   0);
      step();
      step();
      chk("tbl out_valid", 32'(out_valid), 1);
      chk("tbl out_cnt",   32'(out_cnt),   32'(tbl[i].cnt));
      chk("tbl out_last",  32'(out_last),  32'(tbl[i].last));
      chk("tbl out_acc",   32'(out_acc),   AccEn ? 32'(tbl[i].acc) : 0);
      chk("tbl out_ovf",   32'(out_ovf),   AccEn ? 32'(tbl[i].ovf) : 0);
    end
    step();

    // Backpressure: out_ready low for 5 cycles while a 4-beat frame streams in.
    k = 0;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = (c >= 5);
      in_valid  = (k < 4);
      in_data   = bp_data[(k < 4) ? k : 0];
      in_mask   = 32'hFFFF_FFFF;
      in_mode   = 1'b0;
      in_last   = (k == 3);
      #1;
      if (c == 3 || c == 4) chk("bp in_ready stalled", 32'(in_ready), 0);
      if (c == 4) begin
        chk("bp held out_valid", 32'(out_valid), 1);
        chk("bp held out_cnt",   32'(out_cnt),   32);
      end
      if (out_valid && out_ready) begin
        if (n < 4) begin
          chk("bp out_cnt",   32'(out_cnt),  32'(bp_cnt[n]));
          chk("bp out_cycle", 32'(c),        32'(5 + n));
          chk("bp out_last",  32'(out_last), (n == 3) ? 1 : 0);
          chk("bp out_acc",   32'(out_acc),  AccEn ? 32'(bp_acc[n]) : 0);
        end
        n++;
      end
      if (in_valid && in_ready) k++;
      step();
    end
    chk("bp result count", 32'(n), 4);
    chk("bp beats accepted", 32'(k), 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset with two beats in flight after a partial frame has built up an accumulator.
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("rstmid first out_cnt", 32'(out_cnt), 32);
    chk("rstmid first out_acc", 32'(out_acc), AccEn ? 32 : 0);
    drive(32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step();
    drive(32'h0000_00FF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    chk("rstmid out_valid", 32'(out_valid), 0);
    chk("rstmid out_cnt",   32'(out_cnt),   0);
    chk("rstmid out_acc",   32'(out_acc),   0);
    chk("rstmid out_ovf",   32'(out_ovf),   0);
    chk("rstmid in_ready",  32'(in_ready),  1);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rstmid no ghost beat", 32'(out_valid), 0);
    end
    drive(32'h0000_000F, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("rstmid next out_valid", 32'(out_valid), 1);
    chk("rstmid next out_cnt",   32'(out_cnt),   4);
    chk("rstmid next out_acc",   32'(out_acc),   AccEn ? 4 : 0);
    step();

    // Combinational tree: 100 back-to-back random beats, latency 1.
    prev_valid = 1'b0;
    prev_cnt   = 0;
    prev_acc   = 0;
    base       = 0;
    for (int c = 0; c <= 100; c++) begin
      if (prev_valid) begin
        chk("comb out_valid", 32'(s_out_valid), 1);
        chk("comb out_cnt",   32'(s_out_cnt),   32'(prev_cnt));
        chk("comb out_acc",   32'(s_out_acc),   AccEn ? 32'(prev_acc) : 0);
        chk("comb out_ovf",   32'(s_out_ovf),   0);
      end
      chk("comb in_ready", 32'(s_in_ready), 1);
      if (c < 100) begin
        d   = $urandom;
        m   = $urandom;
        md  = 1'($urandom_range(0, 1));
        lst = ($urandom_range(0, 3) == 0);
        s_in_valid = 1'b1;
        s_in_data  = d;
        s_in_mask  = m;
        s_in_mode  = md;
        s_in_last  = lst;
        prev_cnt   = popcnt((md ? ~d : d) & m);
        prev_acc   = base + prev_cnt;
        base       = lst ? 0 : prev_acc;
        prev_valid = 1'b1;
      end else begin
        s_in_valid = 1'b0;
        prev_valid = 1'b0;
      end
      step();
    end
    chk("comb drained out_valid", 32'(s_out_valid), 0);
    chk("comb drained out_cnt",   32'(s_out_cnt),   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
